// File: rtl/quad_enc_gen.sv
// Quadrature encoder generator: emits a Gray-coded A/B pair, one transition
// every half_period clocks, for a commanded number of steps in either direction.
module quad_enc_gen #(
   parameter int STEP_W = 8,
   parameter int DIV_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [DIV_W-1:0]  half_period,
   input  logic              abort,
   output logic              enc_a,
   output logic              enc_b,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] pos
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic              dir;
   logic [STEP_W-1:0] left;
   logic [DIV_W-1:0]  hp;
   logic [DIV_W-1:0]  cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         dir       <= 1'b0;
         left      <= '0;
         hp        <= '0;
         cnt       <= '0;
         enc_a     <= 1'b0;
         enc_b     <= 1'b0;
         pos       <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  dir  <= cmd_dir;
                  left <= cmd_steps;
                  // cnt holds cycles still to wait before the next transition
                  if (half_period == '0) begin
                     hp  <= DIV_W'(1);
                     cnt <= '0;
                  end else begin
                     hp  <= half_period;
                     cnt <= half_period - DIV_W'(1);
                  end
                  if (cmd_steps == '0) begin
                     done <= 1'b1;
                  end else begin
                     state     <= RUN;
                     cmd_ready <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state     <= IDLE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end else if (cnt == '0) begin
                  // Advance from the current Gray state so direction changes stay single-bit
                  if (!dir) begin
                     enc_a <= ~enc_b;
                     enc_b <= enc_a;
                     pos   <= pos + STEP_W'(1);
                  end else begin
                     enc_a <= enc_b;
                     enc_b <= ~enc_a;
                     pos   <= pos - STEP_W'(1);
                  end
                  left <= left - STEP_W'(1);
                  cnt  <= hp - DIV_W'(1);
                  if (left == STEP_W'(1)) begin
                     state     <= IDLE;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     cmd_ready <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - DIV_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_quad_enc_gen.sv
// Directed bench for quad_enc_gen: timing, Gray sequence, abort, reset and wrap.
module tb_quad_enc_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_dir = 1'b0;
   logic [7:0]  cmd_steps = '0;
   logic [15:0] half_period = '0;
   logic        abort = 1'b0;
   logic        enc_a, enc_b, busy, done;
   logic [7:0]  pos;

   int total = 0;
   int bad   = 0;
   logic [1:0] prev_ab;
   logic [1:0] exp_fwd [4];

   quad_enc_gen dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .half_period(half_period),
      .abort(abort), .enc_a(enc_a), .enc_b(enc_b), .busy(busy), .done(done),
      .pos(pos)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command for one edge; returns 1ns after the acceptance edge.
   task automatic issue(input logic d, input logic [7:0] n, input logic [15:0] h);
      cmd_dir = d; cmd_steps = n; half_period = h; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      cmd_steps = 8'hAA; half_period = 16'd7; cmd_dir = ~d;
   endtask

   // Wait for done, checking every cycle that at most one channel toggles.
   task automatic wait_done(input string tag, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         prev_ab = {enc_a, enc_b};
         tick();
         check({tag, "_onebit"}, 32'($countones(prev_ab ^ {enc_a, enc_b}) <= 1), 32'd1);
         if (done) break;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
   endtask

   initial begin
      exp_fwd[0] = 2'b10; exp_fwd[1] = 2'b11; exp_fwd[2] = 2'b01; exp_fwd[3] = 2'b00;
      #12;
      check("rst_ab", {enc_a, enc_b}, 2'b00);
      check("rst_pos", pos, 8'd0);
      check("rst_ready", cmd_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      reset = 1'b0;
      tick();

      // forward 4 steps, hp=3: edges at t+3,6,9,12
      issue(1'b0, 8'd4, 16'd3);
      check("f4_ready_lo", cmd_ready, 1'b0);
      check("f4_busy", busy, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         prev_ab = {enc_a, enc_b};
         tick();
         check("f4_done", done, 32'(k == 12));
         check("f4_ready", cmd_ready, 32'(k == 12));
         if (k % 3 == 0) check("f4_ab", {enc_a, enc_b}, exp_fwd[k/3-1]);
         else check("f4_hold", {enc_a, enc_b}, prev_ab);
      end
      check("f4_pos", pos, 8'd4);

      // back-to-back reverse 2, hp=1: 00 -> 01 -> 11
      issue(1'b1, 8'd2, 16'd1);
      check("r2_done_lo", done, 1'b0);
      tick();
      check("r2_ab1", {enc_a, enc_b}, 2'b01);
      check("r2_pos1", pos, 8'd3);
      tick();
      check("r2_ab2", {enc_a, enc_b}, 2'b11);
      check("r2_pos2", pos, 8'd2);
      check("r2_done", done, 1'b1);

      // hp=0 acts as hp=1: forward 2 from 11 -> 01 -> 00 on consecutive cycles
      issue(1'b0, 8'd2, 16'd0);
      tick();
      check("hp0_ab1", {enc_a, enc_b}, 2'b01);
      tick();
      check("hp0_ab2", {enc_a, enc_b}, 2'b00);
      check("hp0_done", done, 1'b1);
      check("hp0_pos", pos, 8'd4);

      // forward 2 to 11, then reverse 1 -> 10 (single-bit direction change)
      issue(1'b0, 8'd2, 16'd2);
      wait_done("f2", 10);
      check("f2_ab", {enc_a, enc_b}, 2'b11);
      check("f2_pos", pos, 8'd6);
      issue(1'b1, 8'd1, 16'd2);
      wait_done("rv1", 10);
      check("rv1_ab", {enc_a, enc_b}, 2'b10);
      check("rv1_pos", pos, 8'd5);

      // steps=0: done one cycle after acceptance, nothing moves
      tick();
      issue(1'b0, 8'd0, 16'd3);
      check("z_done", done, 1'b1);
      check("z_busy", busy, 1'b0);
      check("z_ready", cmd_ready, 1'b1);
      check("z_ab", {enc_a, enc_b}, 2'b10);
      check("z_pos", pos, 8'd5);
      tick();
      check("z_done_lo", done, 1'b0);
      check("z_ab2", {enc_a, enc_b}, 2'b10);

      // abort: steps=10 hp=5, abort raised after t+12 -> 2 transitions, done at t+13
      issue(1'b0, 8'd10, 16'd5);
      for (int k = 1; k <= 12; k++) tick();
      check("ab_ab_pre", {enc_a, enc_b}, 2'b01);
      check("ab_pos_pre", pos, 8'd7);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_done", done, 1'b1);
      check("ab_busy", busy, 1'b0);
      check("ab_ready", cmd_ready, 1'b1);
      check("ab_pos", pos, 8'd7);
      for (int k = 0; k < 6; k++) tick();
      check("ab_ab_hold", {enc_a, enc_b}, 2'b01);
      check("ab_done_lo", done, 1'b0);

      // async reset mid-run, between clock edges
      issue(1'b0, 8'd10, 16'd2);
      tick(); tick(); tick();
      check("ar_busy_pre", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("ar_ab", {enc_a, enc_b}, 2'b00);
      check("ar_pos", pos, 8'd0);
      check("ar_ready", cmd_ready, 1'b1);
      check("ar_busy", busy, 1'b0);
      tick();
      reset = 1'b0;

      // wrap: reverse 1 from pos 0
      issue(1'b1, 8'd1, 16'd1);
      tick();
      check("wr_pos", pos, 8'hFF);
      check("wr_ab", {enc_a, enc_b}, 2'b01);
      check("wr_done", done, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
